// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer:
// opcode/funct constants, FSM state codes, PCSrc codes and the instruction-class vector.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  typedef enum logic [2:0] {
    ST_IF   = 3'b000,
    ST_ID   = 3'b001,
    ST_EXE  = 3'b010,
    ST_MEM  = 3'b011,
    ST_WB   = 3'b100,
    ST_HALT = 3'b101
  } state_t;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  typedef struct packed {
    logic rtype;
    logic jr;
    logic addi;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic j;
    logic jal;
    logic halt;
    logic illegal;
  } iclass_t;

  localparam int ICLASS_W = $bits(iclass_t);

endpackage

// File: rtl/instr_class_dec.sv
// Combinational opcode/funct decoder producing a one-hot instruction class.
// Zero latency; no flow control.
module instr_class_dec
  import ctrl_pkg::*;
(
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  output logic [ICLASS_W-1:0] cls
);

  iclass_t c;

  always_comb begin
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FUNCT_JR) c.jr = 1'b1;
        else                   c.rtype = 1'b1;
      end
      OP_ADDI: c.addi    = 1'b1;
      OP_LW:   c.lw      = 1'b1;
      OP_SW:   c.sw      = 1'b1;
      OP_BEQ:  c.beq     = 1'b1;
      OP_BNE:  c.bne     = 1'b1;
      OP_J:    c.j       = 1'b1;
      OP_JAL:  c.jal     = 1'b1;
      OP_HALT: c.halt    = 1'b1;
      default: c.illegal = 1'b1;
    endcase
  end

  assign cls = c;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle IF/ID/EXE/MEM/WB sequencer; outputs decoded combinationally from state.
// 2-5 cycles per instruction; MEM stalls while mem_ready is low.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWre,
  output logic [1:0]       PCSrc,
  output logic             IRWre,
  output logic             RegWre,
  output logic             RegDst31,
  output logic             MemRd,
  output logic             MemWre,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  logic [ICLASS_W-1:0] cls_bits;
  iclass_t             c;
  state_t              state_q, state_d;

  instr_class_dec u_dec (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls_bits)
  );

  assign c     = iclass_t'(cls_bits);
  assign state = state_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IF;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (PCWre) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    PCWre    = 1'b0;
    PCSrc    = PCSRC_SEQ;
    IRWre    = 1'b0;
    RegWre   = 1'b0;
    RegDst31 = 1'b0;
    MemRd    = 1'b0;
    MemWre   = 1'b0;
    halted   = 1'b0;
    case (state_q)
      ST_IF: begin
        IRWre   = 1'b1;
        state_d = ST_ID;
      end
      ST_ID: begin
        if (c.j || c.jal) begin
          PCWre    = 1'b1;
          PCSrc    = PCSRC_J;
          RegWre   = c.jal;
          RegDst31 = c.jal;
          state_d  = ST_IF;
        end else if (c.jr) begin
          PCWre   = 1'b1;
          PCSrc   = PCSRC_JR;
          state_d = ST_IF;
        end else if (c.illegal) begin
          PCWre   = 1'b1;
          state_d = ST_IF;
        end else if (c.halt) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXE;
        end
      end
      ST_EXE: begin
        if (c.beq || c.bne) begin
          PCWre   = 1'b1;
          PCSrc   = ((c.beq && zero) || (c.bne && !zero)) ? PCSRC_BR : PCSRC_SEQ;
          state_d = ST_IF;
        end else if (c.lw || c.sw) begin
          state_d = ST_MEM;
        end else if (c.rtype || c.addi) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_IF;
        end
      end
      ST_MEM: begin
        // Request stays asserted until the memory handshakes.
        if (c.lw) begin
          MemRd = 1'b1;
          if (mem_ready) state_d = ST_WB;
        end else if (c.sw) begin
          MemWre = 1'b1;
          if (mem_ready) begin
            PCWre   = 1'b1;
            state_d = ST_IF;
          end
        end else begin
          state_d = ST_IF;
        end
      end
      ST_WB: begin
        RegWre  = 1'b1;
        PCWre   = 1'b1;
        state_d = ST_IF;
      end
      ST_HALT: halted = 1'b1;
      default: state_d = ST_IF;
    endcase
    if (RST) begin
      PCWre    = 1'b0;
      PCSrc    = PCSRC_SEQ;
      IRWre    = 1'b0;
      RegWre   = 1'b0;
      RegDst31 = 1'b0;
      MemRd    = 1'b0;
      MemWre   = 1'b0;
      halted   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: driver pushes per-instruction expectations,
// a negedge monitor accumulates activity and checks it on each PCWre pulse.
module tb_multicycle_ctrl;

  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [5:0]    opcode, funct;
  logic          zero, mem_ready;
  logic          PCWre, IRWre, RegWre, RegDst31, MemRd, MemWre, halted;
  logic [1:0]    PCSrc;
  logic [2:0]    state;
  logic [CW-1:0] retired;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre),
    .RegWre(RegWre), .RegDst31(RegDst31), .MemRd(MemRd), .MemWre(MemWre),
    .halted(halted), .state(state), .retired(retired)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int            len;
    logic [1:0]    pcsrc;
    int            regwre;
    logic          rd31;
    int            memrd;
    int            memwre;
    logic [CW-1:0] ret;
    logic [47:0]   trace;
  } exp_t;

  exp_t          sbq[$];
  int            total = 0;
  int            bad = 0;
  logic [CW-1:0] exp_ret = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] push_st(input logic [47:0] t, input int s);
    return {t[44:0], 3'(s)};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h08, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3f};
  endfunction

  // Reference behaviour of one complete instruction, straight from the opcode rules.
  function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input int waits, input logic [CW-1:0] ret);
    exp_t e;
    bit is_r, is_jr, is_ld, is_st, is_br, is_jmp, is_ill;
    is_jr  = (op == 6'h00) && (fn == 6'h08);
    is_r   = ((op == 6'h00) && !is_jr) || (op == 6'h08);
    is_ld  = (op == 6'h23);
    is_st  = (op == 6'h2b);
    is_br  = (op == 6'h04) || (op == 6'h05);
    is_jmp = (op == 6'h02) || (op == 6'h03);
    is_ill = !is_legal(op);
    e.ret    = ret;
    e.rd31   = (op == 6'h03);
    e.regwre = (e.rd31 || is_r || is_ld) ? 1 : 0;
    e.memrd  = is_ld ? waits + 1 : 0;
    e.memwre = is_st ? waits + 1 : 0;
    e.pcsrc  = is_jmp ? 2'b11 : is_jr ? 2'b10 :
               (op == 6'h04) ? {1'b0, z} : (op == 6'h05) ? {1'b0, !z} : 2'b00;
    e.trace  = push_st(push_st(48'd0, 0), 1);
    if (is_jmp || is_jr || is_ill) begin
      e.len = 2;
    end else begin
      e.trace = push_st(e.trace, 2);
      if (is_ld || is_st)
        for (int k = 0; k <= waits; k++) e.trace = push_st(e.trace, 3);
      if (is_r || is_ld) e.trace = push_st(e.trace, 4);
      e.len = is_br ? 3 : is_st ? 4 + waits : is_ld ? 5 + waits : 4;
    end
    return e;
  endfunction

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z, input int waits);
    exp_t e;
    bit memop;
    e = model(op, fn, z, waits, exp_ret);
    sbq.push_back(e);
    exp_ret = exp_ret + CW'(1);
    memop = (e.memrd + e.memwre) > 0;
    opcode = op;
    funct  = fn;
    zero   = z;
    for (int c = 1; c <= e.len; c++) begin
      if (memop && c >= 4 && c < 4 + waits) mem_ready = 1'b0;
      else if (memop && c == 4 + waits)     mem_ready = 1'b1;
      else                                  mem_ready = 1'($urandom);
      @(posedge CLK); #1;
    end
  endtask

  task automatic run_random();
    logic [5:0] op, fn;
    int k;
    k  = $urandom_range(0, 9);
    fn = 6'($urandom);
    case (k)
      0: op = 6'h00;
      1: begin op = 6'h00; fn = 6'h08; end
      2: op = 6'h08;
      3: op = 6'h23;
      4: op = 6'h2b;
      5: op = 6'h04;
      6: op = 6'h05;
      7: op = 6'h02;
      8: op = 6'h03;
      default: begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end
    endcase
    run(op, fn, 1'($urandom), $urandom_range(0, 3));
  endtask

  // Monitor
  int          cyc = 0, irw = 0, rgw = 0, mrd = 0, mwr = 0;
  logic [47:0] tr = '0;

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST) begin
        cyc = 0; irw = 0; rgw = 0; mrd = 0; mwr = 0; tr = '0;
      end else begin
        cyc++;
        tr  = push_st(tr, int'(state));
        irw += int'(IRWre);
        rgw += int'(RegWre);
        mrd += int'(MemRd);
        mwr += int'(MemWre);
        if (!PCWre) chk("pcsrc_idle", 64'(PCSrc), 64'd0);
        if (PCWre) begin
          chk("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("len",      64'(cyc),      64'(e.len));
            chk("pcsrc",    64'(PCSrc),    64'(e.pcsrc));
            chk("regdst31", 64'(RegDst31), 64'(e.rd31));
            chk("regwre",   64'(rgw),      64'(e.regwre));
            chk("irwre",    64'(irw),      64'd1);
            chk("memrd",    64'(mrd),      64'(e.memrd));
            chk("memwre",   64'(mwr),      64'(e.memwre));
            chk("retired",  64'(retired),  64'(e.ret));
            chk("trace",    64'(tr),       64'(e.trace));
          end
          cyc = 0; irw = 0; rgw = 0; mrd = 0; mwr = 0; tr = '0;
        end
      end
    end
  end

  initial begin
    RST = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_state",   64'(state),   64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    chk("rst_enables", 64'({PCWre, IRWre, RegWre, MemRd, MemWre, halted}), 64'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    exp_ret = '0;

    run(6'h00, 6'h20, 1'b0, 0);   // add
    run(6'h04, 6'h00, 1'b1, 0);   // beq taken
    run(6'h05, 6'h00, 1'b1, 0);   // bne not taken
    run(6'h23, 6'h00, 1'b0, 3);   // lw, 3 wait cycles
    run(6'h03, 6'h00, 1'b0, 0);   // jal
    run(6'h00, 6'h08, 1'b0, 0);   // jr
    run(6'h33, 6'h00, 1'b0, 0);   // illegal
    run(6'h2b, 6'h00, 1'b0, 2);   // sw, 2 wait cycles
    for (int i = 0; i < 30; i++) run_random();

    // halt: parks until reset
    opcode = 6'h3f;
    for (int c = 0; c < 10; c++) begin
      mem_ready = 1'($urandom);
      zero      = 1'($urandom);
      if (c >= 3) begin
        @(negedge CLK);
        chk("halt_flag",    64'(halted),  64'd1);
        chk("halt_state",   64'(state),   64'd5);
        chk("halt_pcwre",   64'(PCWre),   64'd0);
        chk("halt_retired", 64'(retired), 64'(exp_ret));
      end
      @(posedge CLK); #1;
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    exp_ret = '0;

    // sw stalled in MEM, then aborted by reset
    opcode = 6'h2b;
    fork
      begin
        @(negedge CLK);
        chk("post_halt_state",   64'(state),   64'd0);
        chk("post_halt_retired", 64'(retired), 64'd0);
        chk("post_halt_halted",  64'(halted),  64'd0);
      end
      for (int c = 1; c <= 5; c++) begin
        mem_ready = (c < 4) ? 1'($urandom) : 1'b0;
        @(posedge CLK); #1;
      end
    join
    chk("abort_wait_state", 64'(state), 64'd3);
    RST = 1'b1;
    mem_ready = 1'b1;
    @(negedge CLK);
    chk("abort_memwre", 64'(MemWre), 64'd0);
    chk("abort_pcwre",  64'(PCWre),  64'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    exp_ret = '0;
    fork
      begin
        @(negedge CLK);
        chk("abort_state",   64'(state),   64'd0);
        chk("abort_retired", 64'(retired), 64'd0);
      end
      run(6'h02, 6'h00, 1'b0, 0);
    join

    // counter wrap: 16th retirement is an illegal opcode
    while (exp_ret != CW'(15)) run_random();
    run(6'h33, 6'h00, 1'b0, 0);
    fork
      begin
        @(negedge CLK);
        chk("wrap_retired", 64'(retired), 64'd0);
      end
      run(6'h02, 6'h00, 1'b0, 0);
    join

    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the single-issue MIPS core. It steps each instruction through IF/ID/EXE/MEM/WB and pulses `PCWre` exactly once per instruction. It selects the next-PC source `PCSrc` driven into the next-address mux, and drives IR/register-file/data-memory write enables. It also counts retired instructions.

## Interface
Parameters:
- `CNT_W`, 32, width of retired-instruction counter

Ports:
- `CLK`  in  1  clock; all state changes on rising edge
- `RST`  in  1  reset, synchronous, active-high
- `opcode`  in  6  IR[31:26], held stable by IR between IRWre pulses
- `funct`  in  6  IR[5:0]
- `zero`  in  1  ALU zero flag, valid in EXE
- `mem_ready`  in  1  data-memory done handshake, sampled in MEM
- `PCWre`  out  1  PC write enable, one-cycle pulse per instruction
- `PCSrc`  out  2  00 PC+4, 01 branch, 10 jr (ReadData1), 11 jump/jal
- `IRWre`  out  1  instruction register load
- `RegWre`  out  1  register-file write
- `RegDst31`  out  1  write destination is $31 (jal)
- `MemRd`  out  1  data-memory read request
- `MemWre`  out  1  data-memory write request
- `halted`  out  1  core stopped
- `state`  out  3  current state (debug)
- `retired`  out  CNT_W  instructions retired

## Operation
- Opcode classes: R 000000 (jr when funct 001000), addi 001000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011, halt 111111; any other opcode is an illegal opcode, retired as NOP.
- States: IF 000, ID 001, EXE 010, MEM 011, WB 100, HALT 101. The state register is the only FSM storage. Outputs are decoded combinationally from state, opcode, funct, zero and mem_ready.
- IF: IRWre=1; next ID.
- ID behaviour by opcode:
  - j: PCWre=1, PCSrc=11; next IF.
  - jal: PCWre=1, PCSrc=11, RegWre=1, RegDst31=1; next IF.
  - jr: PCWre=1, PCSrc=10; next IF.
  - Illegal opcode: PCWre=1, PCSrc=00; next IF.
  - halt: next HALT with no PCWre.
  - Others: next EXE.
- EXE behaviour by opcode:
  - beq/bne: PCWre=1. PCSrc=01 if (beq&zero)|(bne&!zero), else 00. Next IF.
  - lw/sw: next MEM.
  - R/addi: next WB.
- MEM:
  - lw: MemRd=1 held until mem_ready=1, then next WB.
  - sw: MemWre=1 held until mem_ready=1. In the mem_ready cycle: PCWre=1, PCSrc=00, next IF.
  - mem_ready=0: stay in MEM, no PCWre.
- WB: RegWre=1, PCWre=1, PCSrc=00; next IF.
- HALT: all enables 0, halted=1; exited only by RST.
- `retired` increments by 1 in every cycle where PCWre=1, including an illegal opcode. It wraps from all-ones to 0.
- Unused outputs are 0 in each state. PCSrc=00 whenever PCWre=0.

## Timing
- RST=1 at a clock edge: state←IF, retired←0. While RST=1, all enables, halted and PCSrc are forced to 0, overriding decode. RST mid-instruction (including a MEM wait) aborts it with no PCWre. The first IF occurs in the cycle after RST deasserts.
- Cycles per instruction, mem_ready immediate:
  - j/jal/jr/illegal: 2
  - beq/bne: 3
  - R/addi/sw: 4
  - lw: 5
- Each mem_ready=0 cycle in MEM adds 1 cycle.
- PC updates on the edge that ends the PCWre cycle. IR loads on the edge ending IF.
- mem_ready outside MEM is ignored.

## Structure
- Package `ctrl_pkg`: opcode/funct constants, state encoding, PCSrc encoding (PCSRC_SEQ/BR/JR/J).
- Sub-module `instr_class_dec` (combinational): opcode+funct → one-hot class {rtype, jr, addi, lw, sw, beq, bne, j, jal, halt, illegal}. The FSM is the top-level always block.

## Test plan
- Reset then opcode=000000/funct=100000 (add) → states IF,ID,EXE,WB. RegWre and PCWre in cycle 4 with PCSrc=00; retired=1.
- beq with zero=1 → PCWre with PCSrc=01 in cycle 3. bne with zero=1 → PCSrc=00, retired increments both times.
- lw with mem_ready low for 3 MEM cycles → MemRd high 4 cycles, then WB with RegWre=PCWre=1; total 8 cycles.
- jal → cycle 2 shows PCWre=1, PCSrc=11, RegWre=1, RegDst31=1. jr → PCSrc=10.
- halt → halted=1 and state=101 indefinitely, no PCWre, retired frozen. RST=1 for one edge → state=IF, retired=0, halted=0.
- RST asserted during a sw MEM wait → no MemWre/PCWre after the reset edge. Opcode 110011 (illegal) → 2-cycle NOP with PCSrc=00; retired preset near all-ones wraps to 0.
